tfacc_axi_rdmaster: RTL and testbench

- AXI4 read-burst master that sits between the tfacc memory interface's fetch logic and the M00_AXI read channels (AR/R).
- Accepts one linear fetch request (start address, beat count) at a time.
- Splits the request into legal INCR bursts and streams the returned 128-bit beats to the consumer through an internal FIFO with valid/ready.
- Credit-based issue guarantees RREADY never stalls the interconnect for lack of buffer space.

---
 rtl/tfacc_axi_rdmaster.sv | 209 ++++++++++++++++++++
 tb/tb_tfacc_axi_rdmaster.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tfacc_axi_rdmaster.sv
// AXI4 read-burst master: splits a linear beat request into 4 KB-safe INCR bursts
// and streams returned beats through a credit-protected first-word-fall-through FIFO.
module tfacc_axi_rdmaster #(
  parameter int ID_W       = 4,
  parameter int ADDR_W     = 40,
  parameter int DATA_W     = 128,
  parameter int MAXLEN     = 64,
  parameter int FIFO_DEPTH = 256
) (
  input  logic              M00_AXI_ACLK,
  input  logic              M00_AXI_ARESETN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [19:0]       req_nbeats,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ID_W-1:0]   M00_AXI_ARID,
  output logic [ADDR_W-1:0] M00_AXI_ARADDR,
  output logic [7:0]        M00_AXI_ARLEN,
  output logic [2:0]        M00_AXI_ARSIZE,
  output logic [1:0]        M00_AXI_ARBURST,
  output logic              M00_AXI_ARLOCK,
  output logic [3:0]        M00_AXI_ARCACHE,
  output logic [2:0]        M00_AXI_ARPROT,
  output logic [3:0]        M00_AXI_ARQOS,
  output logic              M00_AXI_ARVALID,
  input  logic              M00_AXI_ARREADY,
  input  logic [ID_W-1:0]   M00_AXI_RID,
  input  logic [DATA_W-1:0] M00_AXI_RDATA,
  input  logic [1:0]        M00_AXI_RRESP,
  input  logic              M00_AXI_RLAST,
  input  logic              M00_AXI_RVALID,
  output logic              M00_AXI_RREADY,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [8:0] MAXLEN_L = 9'(MAXLEN);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [19:0]       rem_q, rem_d;
  logic [19:0]       tot_q, tot_d;
  logic [19:0]       dlv_q, dlv_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic              err_q, err_d;
  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  logic [ADDR_W-1:0] req_base;
  logic [8:0]        len_acc, len_cur;
  logic [20:0]       credits;
  logic              ar_hs, r_hs, pop;
  logic              unused_ok;

  // Longest legal burst from address a with r beats left: capped by MAXLEN and the 4 KB page end.
  function automatic logic [8:0] burst_len(input logic [ADDR_W-1:0] a, input logic [19:0] r);
    logic [8:0] lim;
    lim = 9'd256 - {1'b0, a[11:4]};
    if (MAXLEN_L < lim) lim = MAXLEN_L;
    if ({11'd0, lim} > r) lim = r[8:0];
    return lim;
  endfunction

  assign req_base = {req_addr[ADDR_W-1:4], 4'b0000};
  assign len_acc  = burst_len(req_base, req_nbeats);
  assign len_cur  = burst_len(addr_q, rem_q);
  assign credits  = 21'(FIFO_DEPTH) - 21'(count_q) - 21'(outst_q);

  assign ar_hs = arvalid_q & M00_AXI_ARREADY;
  assign r_hs  = M00_AXI_RVALID & M00_AXI_RREADY;
  assign pop   = dout_valid & dout_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    tot_d     = tot_q;
    dlv_d     = dlv_q;
    err_d     = err_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    case (state_q)
      IDLE: begin
        // FIFO is empty and nothing is outstanding here, so the first burst always has credit.
        if (req_valid && (req_nbeats != 20'd0)) begin
          state_d   = ISSUE;
          addr_d    = req_base;
          rem_d     = req_nbeats;
          tot_d     = req_nbeats;
          dlv_d     = 20'd0;
          err_d     = 1'b0;
          arvalid_d = 1'b1;
          araddr_d  = req_base;
          arlen_d   = 8'(len_acc - 9'd1);
        end
      end
      ISSUE: begin
        if (arvalid_q) begin
          if (M00_AXI_ARREADY) begin
            arvalid_d = 1'b0;
            addr_d    = addr_q + ADDR_W'({len_cur, 4'b0000});
            rem_d     = rem_q - 20'(len_cur);
            if (rem_q == 20'(len_cur)) state_d = DRAIN;
          end
        end else if (credits >= 21'(len_cur)) begin
          arvalid_d = 1'b1;
          araddr_d  = addr_q;
          arlen_d   = 8'(len_cur - 9'd1);
        end
      end
      DRAIN: begin
        if (dlv_q == tot_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (r_hs && (M00_AXI_RRESP != 2'b00)) err_d = 1'b1;
    if (pop) dlv_d = dlv_q + 20'd1;
  end

  always_comb begin
    outst_d = outst_q;
    if (ar_hs) outst_d = outst_d + CNT_W'(len_cur);
    if (r_hs)  outst_d = outst_d - CNT_W'(1);
    count_d  = count_q + CNT_W'(r_hs) - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(r_hs);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  end

  always_ff @(posedge M00_AXI_ACLK or negedge M00_AXI_ARESETN) begin
    if (!M00_AXI_ARESETN) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      tot_q     <= '0;
      dlv_q     <= '0;
      outst_q   <= '0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      tot_q     <= tot_d;
      dlv_q     <= dlv_d;
      outst_q   <= outst_d;
      err_q     <= err_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge M00_AXI_ACLK) begin
    if (r_hs) mem[wr_ptr_q] <= M00_AXI_RDATA;
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DRAIN) && (dlv_q == tot_q);
  assign err       = err_q;

  assign M00_AXI_ARID    = '0;
  assign M00_AXI_ARADDR  = araddr_q;
  assign M00_AXI_ARLEN   = arlen_q;
  assign M00_AXI_ARSIZE  = 3'b100;
  assign M00_AXI_ARBURST = 2'b01;
  assign M00_AXI_ARLOCK  = 1'b0;
  assign M00_AXI_ARCACHE = 4'b0011;
  assign M00_AXI_ARPROT  = 3'b000;
  assign M00_AXI_ARQOS   = 4'h0;
  assign M00_AXI_ARVALID = arvalid_q;
  assign M00_AXI_RREADY  = (outst_q != '0);

  assign dout_valid = (count_q != '0);
  assign dout_data  = mem[rd_ptr_q];
  assign dout_last  = dout_valid && (dlv_q == (tot_q - 20'd1));

  assign unused_ok = ^{req_addr[3:0], M00_AXI_RID};

  // Credits make both of these impossible with a well-behaved slave.
  assert property (@(posedge M00_AXI_ACLK) disable iff (!M00_AXI_ARESETN)
                   !(M00_AXI_RVALID && (count_q == CNT_W'(FIFO_DEPTH))));
  assert property (@(posedge M00_AXI_ACLK) disable iff (!M00_AXI_ARESETN)
                   (r_hs && (outst_q == CNT_W'(1))) |-> M00_AXI_RLAST);

endmodule

// File: tb/tb_tfacc_axi_rdmaster.sv
// Scoreboard bench for tfacc_axi_rdmaster: random AXI slave and consumer, expected
// bursts and beats produced by a page/MAXLEN splitting model at request issue time.
module tb_tfacc_axi_rdmaster;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 40;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid, req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [19:0]       req_nbeats;
  logic              busy, done, err;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic              arvalid, arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready;
  logic              dout_valid, dout_ready, dout_last;
  logic [DATA_W-1:0] dout_data;

  always #5 clk = ~clk;

  tfacc_axi_rdmaster dut (
    .M00_AXI_ACLK(clk), .M00_AXI_ARESETN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_nbeats(req_nbeats),
    .busy(busy), .done(done), .err(err),
    .M00_AXI_ARID(arid), .M00_AXI_ARADDR(araddr), .M00_AXI_ARLEN(arlen), .M00_AXI_ARSIZE(arsize),
    .M00_AXI_ARBURST(arburst), .M00_AXI_ARLOCK(arlock), .M00_AXI_ARCACHE(arcache),
    .M00_AXI_ARPROT(arprot), .M00_AXI_ARQOS(arqos), .M00_AXI_ARVALID(arvalid),
    .M00_AXI_ARREADY(arready),
    .M00_AXI_RID(rid), .M00_AXI_RDATA(rdata), .M00_AXI_RRESP(rresp), .M00_AXI_RLAST(rlast),
    .M00_AXI_RVALID(rvalid), .M00_AXI_RREADY(rready),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data), .dout_last(dout_last)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [ADDR_W-1:0] exp_ar_addr_q[$];
  int                exp_ar_len_q[$];
  logic [DATA_W-1:0] exp_data_q[$];
  bit                exp_last_q[$];
  bit                exp_err_q[$];

  logic [ADDR_W-1:0] sl_addr_q[$];
  int                sl_len_q[$];
  int                sl_beat = 0;
  bit                sl_rstall = 1'b0;
  bit                err_en = 1'b0;
  logic [ADDR_W-1:0] err_addr = '0;
  bit                hold_ready = 1'b0;

  int requested = 0, received = 0, popped = 0, ar_count = 0, done_count = 0;
  bit exp_done_now = 1'b0, exp_idle_now = 1'b0, last_exp_err = 1'b0, ar_pend = 1'b0;
  logic [ADDR_W-1:0] prev_araddr;
  logic [7:0]        prev_arlen;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[31:0] ^ 32'hDEADBEEF, ~a[31:0], a[39:8], a[31:0] + 32'h13579BDF};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportMissing(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got event with nothing expected", name);
  endtask

  // Reference model: walk the request in 4 KB pages, 64 beats at most per burst.
  task automatic modelRequest(input logic [ADDR_W-1:0] addr, input int n, input bit exp_err);
    logic [ADDR_W-1:0] a;
    int r, room, len;
    a = {addr[ADDR_W-1:4], 4'h0};
    for (int i = 0; i < n; i++) begin
      exp_data_q.push_back(mem_word(a + ADDR_W'(16 * i)));
      exp_last_q.push_back(i == n - 1);
    end
    r = n;
    while (r > 0) begin
      room = (4096 - int'(a[11:0])) / 16;
      len = r;
      if (len > 64) len = 64;
      if (len > room) len = room;
      exp_ar_addr_q.push_back(a);
      exp_ar_len_q.push_back(len - 1);
      a = a + ADDR_W'(16 * len);
      r = r - len;
    end
    exp_err_q.push_back(exp_err);
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input int n, input bit exp_err);
    bit accepted;
    accepted = 1'b0;
    @(posedge clk); #1;
    req_addr = addr;
    req_nbeats = 20'(n);
    req_valid = 1'b1;
    for (int c = 0; c < 200 && !accepted; c++) begin
      @(negedge clk);
      if (req_ready) begin
        modelRequest(addr, n, exp_err);
        accepted = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!accepted) begin
      checkOutput("req_accept", {127'd0, req_ready}, 128'd1);
    end else begin
      @(negedge clk);
      checkOutput("busy_after_accept", {127'd0, busy}, 128'd1);
      checkOutput("err_cleared_on_accept", {127'd0, err}, 128'd0);
      checkOutput("arvalid_cycle_after_accept", {127'd0, arvalid}, 128'd1);
      checkOutput("req_ready_while_busy", {127'd0, req_ready}, 128'd0);
    end
  endtask

  task automatic waitDone(input int budget);
    int start, c;
    start = done_count;
    c = 0;
    while (done_count == start && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (done_count == start) checkOutput("done_timeout", 128'(done_count - start), 128'd1);
    repeat (2) @(negedge clk);
    checkOutput("beats_left", 128'(exp_data_q.size()), 128'd0);
    checkOutput("bursts_left", 128'(exp_ar_addr_q.size()), 128'd0);
  endtask

  // Slave: handshakes are sampled at negedge, responses driven just after posedge.
  initial begin
    logic s_ar_hs, s_r_hs;
    logic [ADDR_W-1:0] s_araddr, a;
    logic [7:0] s_arlen;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = '0;
    forever begin
      @(negedge clk);
      s_ar_hs = arvalid && arready;
      s_r_hs = rvalid && rready;
      s_araddr = araddr;
      s_arlen = arlen;
      @(posedge clk); #1;
      if (!rst_n) begin
        sl_addr_q.delete();
        sl_len_q.delete();
        sl_beat = 0;
        arready = 1'b0;
        rvalid = 1'b0;
        rlast = 1'b0;
      end else begin
        if (s_ar_hs) begin
          sl_addr_q.push_back(s_araddr);
          sl_len_q.push_back(int'(s_arlen));
        end
        if (s_r_hs) begin
          rvalid = 1'b0;
          sl_beat++;
          if (sl_beat > sl_len_q[0]) begin
            void'(sl_addr_q.pop_front());
            void'(sl_len_q.pop_front());
            sl_beat = 0;
          end
        end
        if (!rvalid && sl_addr_q.size() > 0 && !sl_rstall && ($urandom % 4 != 0)) begin
          a = sl_addr_q[0] + ADDR_W'(16 * sl_beat);
          rdata = mem_word(a);
          rresp = (err_en && a == err_addr) ? 2'b10 : 2'b00;
          rlast = (sl_beat == sl_len_q[0]);
          rvalid = 1'b1;
        end
        arready = ($urandom % 3) != 0;
      end
    end
  end

  initial begin
    dout_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      dout_ready = !hold_ready && ($urandom % 4 != 0);
    end
  end

  // Monitor: pops the scoreboard on every observed handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      requested = 0; received = 0; popped = 0; ar_count = 0;
      exp_done_now = 1'b0; exp_idle_now = 1'b0; ar_pend = 1'b0;
    end else begin
      if (requested - received > 0) checkOutput("rready_while_outstanding", {127'd0, rready}, 128'd1);
      if (ar_pend) begin
        checkOutput("arvalid_held", {127'd0, arvalid}, 128'd1);
        checkOutput("araddr_held", 128'(araddr), 128'(prev_araddr));
        checkOutput("arlen_held", 128'(arlen), 128'(prev_arlen));
      end
      ar_pend = arvalid && !arready;
      prev_araddr = araddr;
      prev_arlen = arlen;
      if (done || exp_done_now) begin
        checkOutput("done_pulse", {127'd0, done}, {127'd0, exp_done_now});
        if (exp_done_now) begin
          if (exp_err_q.size() > 0) begin
            last_exp_err = exp_err_q.pop_front();
            checkOutput("err_at_done", {127'd0, err}, {127'd0, last_exp_err});
          end else begin
            reportMissing("done_without_request");
          end
          done_count++;
        end
      end
      if (exp_idle_now)
        checkOutput("idle_after_done", {125'd0, req_ready, busy, err}, {125'd0, 1'b1, 1'b0, last_exp_err});
      exp_idle_now = exp_done_now;
      exp_done_now = 1'b0;
      if (arvalid && arready) begin
        if (exp_ar_addr_q.size() == 0) begin
          reportMissing("unexpected_ar");
        end else begin
          checkOutput("araddr", 128'(araddr), 128'(exp_ar_addr_q.pop_front()));
          checkOutput("arlen", 128'(arlen), 128'(exp_ar_len_q.pop_front()));
        end
        checkOutput("ar_const_fields", {107'd0, arid, arsize, arburst, arlock, arcache, arprot, arqos},
                    {107'd0, 4'h0, 3'b100, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0});
        requested += int'(arlen) + 1;
        ar_count++;
        checkOutput("credit_bound", {127'd0, (requested - popped) <= 256}, 128'd1);
      end
      if (rvalid && rready) received++;
      if (dout_valid && dout_ready) begin
        if (exp_data_q.size() == 0) begin
          reportMissing("unexpected_beat");
        end else begin
          checkOutput("dout_data", dout_data, exp_data_q.pop_front());
          exp_done_now = exp_last_q.pop_front();
          checkOutput("dout_last", {127'd0, dout_last}, {127'd0, exp_done_now});
        end
        popped++;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    logic [ADDR_W-1:0] base;
    int n, idx, start;
    bit e;
    req_valid = 1'b0;
    req_addr = '0;
    req_nbeats = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {120'd0, req_ready, busy, done, err, arvalid, rready, dout_valid, dout_last},
                {120'd0, 8'b1000_0000});
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] single burst");
    applyStimulus(40'h1000, 4, 1'b0);
    waitDone(500);

    $display("[TB] 4 KB crossing");
    applyStimulus(40'h0FC0, 8, 1'b0);
    waitDone(500);

    $display("[TB] 300 beats in MAXLEN bursts");
    applyStimulus(40'h0, 300, 1'b0);
    waitDone(5000);

    $display("[TB] zero-beat request ignored");
    @(posedge clk); #1;
    req_addr = 40'h3000;
    req_nbeats = 20'd0;
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("zero_req_busy", {127'd0, busy}, 128'd0);
    checkOutput("zero_req_arvalid", {127'd0, arvalid}, 128'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;

    $display("[TB] consumer stalled for 1000 cycles");
    hold_ready = 1'b1;
    applyStimulus(40'h0, 600, 1'b0);
    repeat (1000) @(negedge clk);
    checkOutput("stall_arvalid_low", {127'd0, arvalid}, 128'd0);
    checkOutput("stall_beats_ahead", 128'(requested - popped), 128'd256);
    checkOutput("stall_fifo_full_visible", {127'd0, dout_valid}, 128'd1);
    hold_ready = 1'b0;
    waitDone(10000);

    $display("[TB] error response on beat 2");
    err_en = 1'b1;
    err_addr = 40'h2010;
    applyStimulus(40'h2000, 4, 1'b1);
    waitDone(500);
    err_en = 1'b0;

    $display("[TB] random requests");
    for (int t = 0; t < 6; t++) begin
      base = {8'($urandom_range(0, 254)), 32'($urandom)};
      n = $urandom_range(1, 200);
      e = ($urandom % 2) == 1;
      idx = $urandom_range(0, n - 1);
      err_en = e;
      err_addr = {base[ADDR_W-1:4], 4'h0} + ADDR_W'(16 * idx);
      applyStimulus(base, n, e);
      waitDone(5000);
      err_en = 1'b0;
    end

    $display("[TB] reset with bursts outstanding");
    sl_rstall = 1'b1;
    start = ar_count;
    applyStimulus(40'h4000, 600, 1'b0);
    for (int c = 0; c < 200 && (ar_count - start) < 2; c++) @(negedge clk);
    checkOutput("bursts_before_reset", {127'd0, (ar_count - start) >= 2}, 128'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                {122'd0, arvalid, rready, dout_valid, busy, req_ready, done},
                {122'd0, 6'b000010});
    exp_ar_addr_q.delete();
    exp_ar_len_q.delete();
    exp_data_q.delete();
    exp_last_q.delete();
    exp_err_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sl_rstall = 1'b0;
    applyStimulus(40'h5000, 4, 1'b0);
    waitDone(500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
